// File: rtl/cache_line_mem_bridge.sv
// cache_line_mem_bridge: turns one line-wide SRAM read/write from the cache into
// BEATS sequential narrow beats on a req/ack memory bus, reassembling read lines.
module cache_line_mem_bridge #(
    parameter  int SRAM_ADDR_BIT = 9,
    parameter  int SRAM_DATA_BIT = 1024,
    parameter  int MEM_DATA_BIT  = 64,
    localparam int BEATS         = SRAM_DATA_BIT / MEM_DATA_BIT,
    localparam int BEAT_BIT      = $clog2(BEATS)
) (
    input  logic                              clk_sys_i,
    input  logic                              rst_sys_i,
    input  logic                              SRAM_ena_i,
    input  logic                              SRAM_wea_i,
    input  logic [SRAM_ADDR_BIT-1:0]          SRAM_addr_i,
    input  logic [SRAM_DATA_BIT-1:0]          SRAM_data_i,
    output logic [SRAM_DATA_BIT-1:0]          SRAM_data_o,
    output logic                              SRAM_ready_o,
    output logic                              SRAM_valid_o,
    output logic                              MEM_req_o,
    output logic                              MEM_we_o,
    output logic [SRAM_ADDR_BIT+BEAT_BIT-1:0] MEM_addr_o,
    output logic [MEM_DATA_BIT-1:0]           MEM_data_o,
    input  logic [MEM_DATA_BIT-1:0]           MEM_data_i,
    input  logic                              MEM_ack_i
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic                     wea_q;
    logic [SRAM_ADDR_BIT-1:0] addr_q;
    logic [BEAT_BIT-1:0]      beat_q;
    logic                     last_beat;
    logic                     accept;
    logic                     beat_done;

    // Beat-indexed view of the line: one register serves as write source and read buffer.
    logic [BEATS-1:0][MEM_DATA_BIT-1:0] line_q;
    logic [BEATS-1:0][MEM_DATA_BIT-1:0] line_cap;

    assign last_beat  = (beat_q == BEAT_BIT'(BEATS - 1));
    assign accept     = (state_q == IDLE) && SRAM_ena_i;
    assign beat_done  = (state_q == XFER) && MEM_ack_i;
    assign MEM_addr_o = {addr_q, beat_q};
    assign MEM_data_o = line_q[beat_q];

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            state_q <= IDLE;
        end else begin
            // NOTE: state elements use non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first, so no path can infer a latch.
        state_d      = state_q;
        SRAM_ready_o = 1'b0;
        SRAM_valid_o = 1'b0;
        MEM_req_o    = 1'b0;
        MEM_we_o     = 1'b0;
        unique case (state_q)
            IDLE: begin
                SRAM_ready_o = 1'b1;
                if (SRAM_ena_i) state_d = XFER;
            end
            XFER: begin
                MEM_req_o = 1'b1;
                MEM_we_o  = wea_q;
                if (MEM_ack_i && last_beat) state_d = DONE;
            end
            DONE: begin
                SRAM_valid_o = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Buffer with the current beat merged in, so the completed line can be published
    // on the same edge that captures the final beat.
    always_comb begin
        line_cap         = line_q;
        line_cap[beat_q] = MEM_data_i;
    end

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            wea_q       <= 1'b0;
            addr_q      <= '0;
            beat_q      <= '0;
            // NOTE: the wide line registers are reset deliberately; outputs must read zero after reset.
            line_q      <= '0;
            SRAM_data_o <= '0;
        end else if (accept) begin
            wea_q  <= SRAM_wea_i;
            addr_q <= SRAM_addr_i;
            beat_q <= '0;
            if (SRAM_wea_i) line_q <= SRAM_data_i;
        end else if (beat_done) begin
            beat_q <= beat_q + BEAT_BIT'(1);
            if (!wea_q) begin
                line_q <= line_cap;
                if (last_beat) SRAM_data_o <= line_cap;
            end
        end
    end

endmodule

// File: tb/tb_cache_line_mem_bridge.sv
// Self-checking bench for cache_line_mem_bridge: directed line transfers plus a
// randomized phase, checked against a word-addressed memory model and a line-level read model.
module tb_cache_line_mem_bridge;

    localparam int AW    = 9;
    localparam int DW    = 1024;
    localparam int MW    = 64;
    localparam int BEATS = DW / MW;
    localparam int BW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          SRAM_ena_i;
    logic          SRAM_wea_i;
    logic [AW-1:0] SRAM_addr_i;
    logic [DW-1:0] SRAM_data_i;
    logic [DW-1:0] SRAM_data_o;
    logic          SRAM_ready_o;
    logic          SRAM_valid_o;
    logic          MEM_req_o;
    logic          MEM_we_o;
    logic [AW+BW-1:0] MEM_addr_o;
    logic [MW-1:0] MEM_data_o;
    logic [MW-1:0] MEM_data_i;
    logic          MEM_ack_i;

    always #5 clk = ~clk;

    cache_line_mem_bridge #(
        .SRAM_ADDR_BIT(AW),
        .SRAM_DATA_BIT(DW),
        .MEM_DATA_BIT (MW)
    ) dut (
        .clk_sys_i   (clk),
        .rst_sys_i   (rst),
        .SRAM_ena_i  (SRAM_ena_i),
        .SRAM_wea_i  (SRAM_wea_i),
        .SRAM_addr_i (SRAM_addr_i),
        .SRAM_data_i (SRAM_data_i),
        .SRAM_data_o (SRAM_data_o),
        .SRAM_ready_o(SRAM_ready_o),
        .SRAM_valid_o(SRAM_valid_o),
        .MEM_req_o   (MEM_req_o),
        .MEM_we_o    (MEM_we_o),
        .MEM_addr_o  (MEM_addr_o),
        .MEM_data_o  (MEM_data_o),
        .MEM_data_i  (MEM_data_i),
        .MEM_ack_i   (MEM_ack_i)
    );

    // Reference model: next-level memory word array and the line the cache should see.
    logic [MW-1:0]                mem [0:(1<<(AW+BW))-1];
    logic [BEATS-1:0][MW-1:0]     exp_rd;
    logic [BEATS-1:0][MW-1:0]     rd_view;
    int                           stall_cfg [BEATS];
    int                           checks = 0;
    int                           errors = 0;

    assign rd_view = SRAM_data_o;

    task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_line(input string tag);
        for (int k = 0; k < BEATS; k++) check(tag, rd_view[BW'(k)], exp_rd[BW'(k)]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(SRAM_ready_o), 64'd1);
        check({tag, "_valid"}, 64'(SRAM_valid_o), 64'd0);
        check({tag, "_req"},   64'(MEM_req_o),    64'd0);
        check({tag, "_we"},    64'(MEM_we_o),     64'd0);
        check({tag, "_addr"},  64'(MEM_addr_o),   64'd0);
        check({tag, "_mdata"}, MEM_data_o,        64'd0);
        check_line({tag, "_line"});
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW/32-1:0][31:0] r;
        for (int i = 0; i < DW / 32; i++) r[5'(i)] = $urandom;
        return r;
    endfunction

    function automatic logic [MW-1:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    // Runs one line transfer as the cache and the memory; starts and ends #1 after an edge.
    task automatic do_line(input logic wr, input logic [AW-1:0] a,
                           input logic [BEATS-1:0][MW-1:0] wline,
                           input int busy_beat, input int abort_beat);
        int   beat;
        int   c;
        int   stall;
        int   total_stall;
        logic pulsed;
        c = 0;
        while (!SRAM_ready_o && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        check("ready_before_req", 64'(SRAM_ready_o), 64'd1);
        total_stall = 0;
        for (int k = 0; k < BEATS; k++) total_stall += stall_cfg[k];

        SRAM_ena_i  = 1'b1;
        SRAM_wea_i  = wr;
        SRAM_addr_i = a;
        SRAM_data_i = wr ? DW'(wline) : rand_line();
        @(posedge clk); #1;
        SRAM_ena_i  = 1'b0;
        SRAM_data_i = rand_line();

        beat   = 0;
        c      = 0;
        stall  = stall_cfg[0];
        pulsed = 1'b0;
        while (!SRAM_valid_o && c < 300) begin
            check("xfer_req",   64'(MEM_req_o),    64'd1);
            check("xfer_ready", 64'(SRAM_ready_o), 64'd0);
            check("xfer_we",    64'(MEM_we_o),     64'(wr));
            check("xfer_addr",  64'(MEM_addr_o),   64'({a, BW'(beat)}));
            if (wr) check("xfer_wdata", MEM_data_o, wline[BW'(beat)]);
            if (beat == abort_beat) begin
                MEM_ack_i = 1'b0;
                rst       = 1'b1;
                #1;
                exp_rd = '0;
                check_reset_outputs("abort");
                repeat (2) begin
                    @(posedge clk); #1;
                    check("abort_no_valid", 64'(SRAM_valid_o), 64'd0);
                end
                rst = 1'b0;
                return;
            end
            SRAM_ena_i = 1'b0;
            if (beat == busy_beat && !pulsed) begin
                SRAM_ena_i  = 1'b1;
                SRAM_wea_i  = ~wr;
                SRAM_addr_i = ~a;
                pulsed      = 1'b1;
            end
            if (stall > 0) begin
                MEM_ack_i  = 1'b0;
                MEM_data_i = rand_word();
                stall--;
            end else begin
                MEM_ack_i = 1'b1;
                if (wr) mem[{a, BW'(beat)}] = wline[BW'(beat)];
                else    MEM_data_i = mem[{a, BW'(beat)}];
                beat++;
                if (beat < BEATS) stall = stall_cfg[beat];
            end
            @(posedge clk); #1;
            c++;
        end
        MEM_ack_i  = 1'b0;
        SRAM_ena_i = 1'b0;
        check("valid_pulse", 64'(SRAM_valid_o), 64'd1);
        check("latency",     64'(c + 1),        64'(BEATS + 1 + total_stall));
        check("done_ready",  64'(SRAM_ready_o), 64'd0);
        check("done_req",    64'(MEM_req_o),    64'd0);
        if (!wr) for (int k = 0; k < BEATS; k++) exp_rd[BW'(k)] = mem[{a, BW'(k)}];
        check_line(wr ? "line_kept_on_write" : "line_at_valid");
        @(posedge clk); #1;
        check("valid_one_cycle",  64'(SRAM_valid_o), 64'd0);
        check("ready_after_done", 64'(SRAM_ready_o), 64'd1);
    endtask

    initial begin
        logic [BEATS-1:0][MW-1:0] line;
        logic                     wr;
        logic [AW-1:0]            a;

        rst         = 1'b1;
        SRAM_ena_i  = 1'b0;
        SRAM_wea_i  = 1'b0;
        SRAM_addr_i = '0;
        SRAM_data_i = '0;
        MEM_data_i  = '0;
        MEM_ack_i   = 1'b0;
        exp_rd      = '0;
        for (int i = 0; i < (1 << (AW + BW)); i++) mem[i] = rand_word();
        for (int k = 0; k < BEATS; k++) stall_cfg[k] = 0;

        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Line write, ack tied high
        for (int k = 0; k < BEATS; k++) line[BW'(k)] = 64'h0123456789abcdef + 64'(k);
        do_line(1'b1, 9'h040, line, -1, -1);

        // Line read from a pattern-filled line
        for (int k = 0; k < BEATS; k++) mem[{9'h041, BW'(k)}] = 64'hA5A5_0000_0000_0000 | 64'(k);
        do_line(1'b0, 9'h041, '0, -1, -1);

        // Spurious ack while idle: nothing moves, address rests at beat 0 of the last line
        MEM_ack_i = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("spur_ready", 64'(SRAM_ready_o), 64'd1);
            check("spur_req",   64'(MEM_req_o),    64'd0);
            check("spur_valid", 64'(SRAM_valid_o), 64'd0);
            check("spur_addr",  64'(MEM_addr_o),   64'({9'h041, 4'h0}));
        end
        MEM_ack_i = 1'b0;
        check_line("spur_line");

        // Read with three-cycle stalls before beats 0, 7 and 15 (reads back the written line)
        stall_cfg[0] = 3; stall_cfg[7] = 3; stall_cfg[15] = 3;
        do_line(1'b0, 9'h040, '0, -1, -1);
        for (int k = 0; k < BEATS; k++) stall_cfg[k] = 0;

        // Busy drop, then a back-to-back write accepted right after the DONE cycle
        do_line(1'b0, 9'h042, '0, 5, -1);
        do_line(1'b1, 9'h043, rand_line(), 9, -1);

        // Reset mid-read, then a fresh read
        do_line(1'b0, 9'h044, '0, -1, 5);
        do_line(1'b0, 9'h041, '0, -1, -1);

        // Randomized mix over a small address window so reads revisit written lines
        for (int i = 0; i < 12; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 9'h100 + 9'($urandom_range(0, 3));
            for (int k = 0; k < BEATS; k++)
                stall_cfg[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            line = rand_line();
            do_line(wr, a, line, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
